// File: rtl/folding_2.sv
// Two-fold folded 2nd-order IIR: y(n) = x(n) + a*y(n-1) + b*y(n-2).
// One multiplier and one adder are shared across phase A (switch=1) and phase B (switch=0).
module folding_2 #(
   parameter int unsigned n = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [n-1:0] Xn,
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   input  logic         switch,
   output logic [n-1:0] Yn
);

   logic [n-1:0] acc;
   logic [n-1:0] y1;
   logic [n-1:0] y2;

   logic [n-1:0] mul_coef;
   logic [n-1:0] mul_data;
   logic [n-1:0] prod;
   logic [n-1:0] add_in;
   logic [n-1:0] sum;

   // Operand muxes feeding the single shared multiplier and adder
   always_comb begin
      mul_coef = switch ? b  : a;
      mul_data = switch ? y2 : y1;
      add_in   = switch ? Xn : acc;
   end

   // Low n bits of a two's-complement product do not depend on signedness
   assign prod = mul_coef * mul_data;
   assign sum  = add_in + prod;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc <= '0;
         y1  <= '0;
         y2  <= '0;
         Yn  <= '0;
      end else if (switch) begin
         acc <= sum;
      end else begin
         Yn <= sum;
         y2 <= y1;
         y1 <= sum;
      end
   end

endmodule

// File: tb/tb_folding_2.sv
// Self-checking bench for folding_2: table-driven sequences with a scoreboard queue,
// async reset, wrap-around, phase-hold and a randomised run against a direct-form model.
module tb_folding_2;

   localparam int unsigned N = 16;

   logic         clk;
   logic         rst;
   logic [N-1:0] Xn;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         switch;
   logic [N-1:0] Yn;

   folding_2 #(.n(N)) dut (
      .clk    (clk),
      .rst    (rst),
      .Xn     (Xn),
      .a      (a),
      .b      (b),
      .switch (switch),
      .Yn     (Yn)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] x;
      logic [N-1:0] y;
   } vec_t;

   vec_t         imp_tab [5];
   vec_t         nom_tab [7];
   logic [N-1:0] exp_q [$];
   logic [N-1:0] prev_y;
   logic [N-1:0] m_y1;
   logic [N-1:0] m_y2;
   int           checks;
   int           errors;

   task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, $signed(act), act,
                  $signed(exp), exp);
      end
   endtask

   // One sample over a phase pair; expected value queued when stimulus is driven
   task automatic do_pair(input logic [N-1:0] x, input logic [N-1:0] exp_y, input string name);
      logic [N-1:0] want;
      @(negedge clk);
      Xn     = x;
      switch = 1'b1;
      exp_q.push_back(exp_y);
      @(posedge clk);
      #1 check({name, " hold on phase A"}, Yn, prev_y);
      @(negedge clk);
      switch = 1'b0;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: scoreboard empty, got %0d", name, $signed(Yn));
      end else begin
         want = exp_q.pop_front();
         check(name, Yn, want);
         prev_y = want;
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst    = 1'b0;
      switch = 1'b1;
      Xn     = '0;
      repeat (2) @(negedge clk);
      rst    = 1'b1;
      prev_y = '0;
      m_y1   = '0;
      m_y2   = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [N-1:0] x;
      logic [N-1:0] y;

      imp_tab[0] = '{x: 16'd1, y: 16'd1};
      imp_tab[1] = '{x: 16'd0, y: 16'd2};
      imp_tab[2] = '{x: 16'd0, y: 16'd7};
      imp_tab[3] = '{x: 16'd0, y: 16'd20};
      imp_tab[4] = '{x: 16'd0, y: 16'd61};

      nom_tab[0] = '{x: -16'sd3, y: -16'sd3};
      nom_tab[1] = '{x:  16'sd5, y: -16'sd1};
      nom_tab[2] = '{x:  16'sd2, y: -16'sd9};
      nom_tab[3] = '{x: -16'sd2, y: -16'sd23};
      nom_tab[4] = '{x:  16'sd4, y: -16'sd69};
      nom_tab[5] = '{x:  16'sd1, y: -16'sd206};
      nom_tab[6] = '{x:  16'sd1, y: -16'sd618};

      checks = 0;
      errors = 0;
      prev_y = '0;
      m_y1   = '0;
      m_y2   = '0;
      rst    = 1'b0;
      Xn     = '0;
      a      = '0;
      b      = '0;
      switch = 1'b0;

      // Held in reset with busy random inputs: output must stay zero
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         Xn     = N'($urandom);
         a      = N'($urandom);
         b      = N'($urandom);
         switch = ~switch;
         @(posedge clk);
         #1 check("reset hold", Yn, '0);
      end

      a = 16'd2;
      b = 16'd3;
      apply_reset();
      for (int i = 0; i < 5; i++) do_pair(imp_tab[i].x, imp_tab[i].y, $sformatf("impulse[%0d]", i));

      apply_reset();
      for (int i = 0; i < 7; i++) do_pair(nom_tab[i].x, nom_tab[i].y, $sformatf("nominal[%0d]", i));

      a = 16'h4000;
      b = 16'h0000;
      apply_reset();
      do_pair(16'd4, 16'd4, "wrap[0]");
      do_pair(16'd0, 16'd0, "wrap[1]");

      // Asynchronous reset between edges, then replay from zero state
      a = 16'd2;
      b = 16'd3;
      apply_reset();
      for (int i = 0; i < 3; i++) do_pair(nom_tab[i].x, nom_tab[i].y, $sformatf("pre-reset[%0d]", i));
      #2 rst = 1'b0;
      #1 check("async reset no edge", Yn, '0);
      @(negedge clk);
      rst    = 1'b1;
      switch = 1'b1;
      Xn     = '0;
      prev_y = '0;
      for (int i = 0; i < 2; i++) do_pair(nom_tab[i].x, nom_tab[i].y, $sformatf("replay[%0d]", i));

      // Random coefficients and samples against a direct-form model
      a = N'($urandom_range(0, 15)) - 16'd7;
      b = N'($urandom_range(0, 15)) - 16'd7;
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         x    = N'($urandom);
         y    = x + a * m_y1 + b * m_y2;
         m_y2 = m_y1;
         m_y1 = y;
         do_pair(x, y, $sformatf("random[%0d]", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
